// File: rtl/memoria_stream_writer.sv
// memoria_stream_writer: packs a valid/ready byte stream little-endian into
// 32-bit words and writes them to a single-port Avalon RAM slave, one frame per start.
// Latency: 4th byte accepted in cycle N -> mem_write in cycle N+1 (4 bytes / 5 cycles).
// Backpressure: in_ready is high only while collecting bytes; it drops during the write
// cycle(s) and once the frame has ended, so excess bytes stay pending upstream.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start, frame_words   arm a frame (length in words, 0 = until in_last)
//   in_valid/in_ready/in_data/in_last   byte stream
//   mem_*                Avalon slave master side (mem_readdata used by readback only)
//   busy, done           frame in progress / one-cycle end-of-frame pulse
//   word_count, wrapped  words written in this/last frame, address wrapped
//   verify_err           sticky readback mismatch
//
// Optional readback check: define MEMORIA_STREAM_WRITER_VERIFY_EN to read every written
// word back and compare it on the enabled lanes (4 bytes / 7 cycles).
module memoria_stream_writer #(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 12500,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_count,
  output logic              wrapped,
  output logic              verify_err
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

`ifdef MEMORIA_STREAM_WRITER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE, S_RD, S_CMP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr;
  logic [31:0]       r_data;
  logic [3:0]        r_be;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_fw;
  logic              r_wrapped;

  logic              w_accept;
  logic              w_commit;     // cycle in which the word is retired
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_frame_end;
  logic              w_at_last;

  assign w_accept    = in_valid & in_ready;
  assign w_cnt_nxt   = r_count + 1'b1;
  // Frame ends on a taken in_last or when the programmed word count is reached.
  assign w_frame_end = r_last | ((r_fw != '0) && (w_cnt_nxt == r_fw));
  assign w_at_last   = (r_addr == LP_LAST);

`ifdef MEMORIA_STREAM_WRITER_VERIFY_EN
  logic        r_verify_err;
  logic [31:0] w_lane_mask;
  logic        w_mismatch;
  assign w_commit    = (r_state == S_CMP);
  assign w_lane_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  // RAM has one cycle of read latency: data addressed in RD is valid in CMP.
  assign w_mismatch  = (((mem_readdata ^ r_data) & w_lane_mask) != 32'd0);
  assign verify_err  = r_verify_err;
`else
  logic w_unused_rd;
  assign w_commit    = (r_state == S_WRITE);
  assign w_unused_rd = ^mem_readdata;
  assign verify_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    in_ready       = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = 4'b0000;
    mem_address    = '0;
    mem_writedata  = 32'd0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && ((r_ptr == 2'd3) || in_last)) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = r_be;
        mem_address    = r_addr;
        mem_writedata  = r_data;
`ifdef MEMORIA_STREAM_WRITER_VERIFY_EN
        w_state_nxt    = S_RD;
`else
        w_state_nxt    = w_frame_end ? S_DONE : S_FILL;
`endif
      end
`ifdef MEMORIA_STREAM_WRITER_VERIFY_EN
      S_RD: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_byteenable = r_be;
        mem_address    = r_addr;
        w_state_nxt    = S_CMP;
      end
      S_CMP: begin
        busy        = 1'b1;
        w_state_nxt = w_frame_end ? S_DONE : S_FILL;
      end
`endif
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= 2'd0;
      r_data    <= 32'd0;
      r_be      <= 4'b0000;
      r_last    <= 1'b0;
      r_addr    <= LP_BASE;
      r_count   <= '0;
      r_fw      <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_fw      <= frame_words;
        r_count   <= '0;
        r_wrapped <= 1'b0;
        r_addr    <= LP_BASE;
        r_ptr     <= 2'd0;
        r_data    <= 32'd0;
        r_be      <= 4'b0000;
        r_last    <= 1'b0;
      end
      if (w_accept) begin
        for (int i = 0; i < 4; i++) begin
          if (r_ptr == 2'(i)) begin
            r_data[8*i +: 8] <= in_data;
            r_be[i]          <= 1'b1;
          end
        end
        r_ptr  <= r_ptr + 2'd1;
        r_last <= in_last;
      end
      if (w_commit) begin
        r_count <= w_cnt_nxt;
        r_ptr   <= 2'd0;
        r_data  <= 32'd0;
        r_be    <= 4'b0000;
        if (w_at_last) begin
          r_addr    <= LP_BASE;
          r_wrapped <= 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

`ifdef MEMORIA_STREAM_WRITER_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_verify_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_verify_err <= 1'b0;
    end else if (w_commit && w_mismatch) begin
      r_verify_err <= 1'b1;
    end
  end
`endif

  assign mem_clken  = 1'b1;
  assign word_count = r_count;
  assign wrapped    = r_wrapped;

endmodule
